io_bridge: RTL and testbench

Byte-wide memory/IO bridge directly downstream of the CPU core's external bus (address, data-out, write strobe, data-in, `io_buffer_full`). It decodes each CPU access to either the 128 KiB block RAM or the memory-mapped IO window. It buffers UART output bytes in a FIFO and serialises them 8N1 on `uart_tx`. It drives `io_buffer_full` back to the CPU early enough that in-flight stores never overflow.

---
 rtl/io_bridge_pkg.sv | 16 +
 rtl/io_bridge_if.sv | 21 ++
 rtl/io_bridge_uart_tx_fifo.sv | 125 ++++++++++++
 rtl/io_bridge.sv | 81 ++++++++
 tb/tb_io_bridge.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bridge_pkg.sv
// Shared IO address map and UART transmitter state encodings for the io_bridge slice.
package io_bridge_pkg;

  localparam logic [17:0] IO_BASE        = 18'h30000;
  localparam logic [17:0] IO_UART_ADDR   = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR   = 18'h30004;
  localparam logic [17:0] IO_STATUS_ADDR = 18'h30004;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/io_bridge_if.sv
// CPU external bus: master is the core, slave is the bridge; no handshake beyond rdy_in and io_buffer_full.
interface io_bridge_if;

  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;

  modport master (
    output rdy_in, cpu_a, cpu_dout, cpu_wr,
    input  cpu_din, io_buffer_full
  );

  modport slave (
    input  rdy_in, cpu_a, cpu_dout, cpu_wr,
    output cpu_din, io_buffer_full
  );

endinterface

// File: rtl/io_bridge_uart_tx_fifo.sv
// UART TX byte FIFO feeding an 8N1 serialiser; a push is seen by the FSM one cycle later.
// No backpressure on push: a push into a full FIFO without a same-edge pop is dropped and flagged.
module uart_tx_fifo
  import io_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG = 4,
  parameter int FULL_SLACK     = 2,
  parameter int BAUD_DIV       = 868
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_dat,
  output logic       fifo_empty,
  output logic       near_full,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int PW    = FIFO_DEPTH_LOG + 1;
  localparam int PW1   = PW + 1;
  localparam int BW    = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [PW:0]   DEPTH_W   = PW1'(DEPTH);
  localparam logic [PW:0]   SLACK_W   = PW1'(FULL_SLACK);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] head, tail, count;
  logic [PW:0]   free_cnt;
  logic          full, pop, push_ok;
  uart_state_t   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign count      = tail - head;
  assign fifo_empty = (head == tail);
  assign full       = (head[FIFO_DEPTH_LOG-1:0] == tail[FIFO_DEPTH_LOG-1:0]) &&
                      (head[PW-1] != tail[PW-1]);
  assign free_cnt   = DEPTH_W - {1'b0, count};
  assign near_full  = (free_cnt <= SLACK_W);

  // Pops only happen when a new frame is launched: from idle, or straight out of a finished stop bit.
  assign pop     = !fifo_empty && ((state == UART_IDLE) || (state == UART_STOP && baud == '0));
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[tail[FIFO_DEPTH_LOG-1:0]] <= push_dat;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head     <= '0;
      tail     <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) head <= head + PW'(1);
      if (push_ok) tail <= tail + PW'(1);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= UART_IDLE;
      uart_tx <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        UART_IDLE: begin
          if (pop) begin
            shift   <= mem[head[FIFO_DEPTH_LOG-1:0]];
            baud    <= BAUD_LAST;
            uart_tx <= 1'b0;
            state   <= UART_START;
          end
        end
        UART_START: begin
          if (baud == '0) begin
            baud    <= BAUD_LAST;
            bit_idx <= '0;
            uart_tx <= shift[0];
            state   <= UART_DATA;
          end else begin
            baud <= baud - BW'(1);
          end
        end
        UART_DATA: begin
          if (baud == '0) begin
            baud <= BAUD_LAST;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= UART_STOP;
            end else begin
              shift   <= shift >> 1;
              uart_tx <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud - BW'(1);
          end
        end
        UART_STOP: begin
          if (baud == '0) begin
            if (pop) begin
              shift   <= mem[head[FIFO_DEPTH_LOG-1:0]];
              baud    <= BAUD_LAST;
              uart_tx <= 1'b0;
              state   <= UART_START;
            end else begin
              state <= UART_IDLE;
            end
          end else begin
            baud <= baud - BW'(1);
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Decodes CPU accesses to block RAM or the IO window; loads return exactly one accepted cycle later.
// Stores are throttled only through io_buffer_full, raised while FULL_SLACK or fewer FIFO slots remain.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG = 4,
  parameter int FULL_SLACK     = 2,
  parameter int BAUD_DIV       = 868
) (
  input  logic        clk_in,
  input  logic        rst_in,
  io_bridge_if.slave  cpu,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        uart_tx,
  output logic        sim_halt,
  output logic        fifo_overflow
);

  logic [17:0] addr;
  logic        io, io_wr, push, halt_wr, fifo_empty, near_full;
  logic        acc_q, sel_io;
  logic [7:0]  io_rd, sel_val, din_hold, din;
  logic        unused_addr_hi;

  assign addr           = cpu.cpu_a[17:0];
  assign unused_addr_hi = ^cpu.cpu_a[31:18];
  assign io             = (addr[17:16] == IO_BASE[17:16]);

  assign ram_en   = cpu.rdy_in & ~io;
  assign ram_wr   = cpu.cpu_wr;
  assign ram_a    = addr[16:0];
  assign ram_dout = cpu.cpu_dout;

  assign io_wr   = cpu.rdy_in & io & cpu.cpu_wr;
  assign push    = io_wr && (addr == IO_UART_ADDR);
  assign halt_wr = io_wr && (addr == IO_HALT_ADDR);
  assign io_rd   = (addr == IO_STATUS_ADDR) ? {7'b0, fifo_empty} : 8'h00;

  // din_hold keeps the last returned byte so cpu_din freezes while the CPU is stalled.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_q    <= 1'b0;
      sel_io   <= 1'b0;
      sel_val  <= 8'h00;
      din_hold <= 8'h00;
      sim_halt <= 1'b0;
    end else begin
      acc_q    <= cpu.rdy_in;
      din_hold <= din;
      sim_halt <= halt_wr;
      if (cpu.rdy_in) begin
        sel_io  <= io;
        sel_val <= io_rd;
      end
    end
  end

  assign din                = !acc_q ? din_hold : (sel_io ? sel_val : ram_din);
  assign cpu.cpu_din        = din;
  assign cpu.io_buffer_full = near_full;

  uart_tx_fifo #(
    .FIFO_DEPTH_LOG (FIFO_DEPTH_LOG),
    .FULL_SLACK     (FULL_SLACK),
    .BAUD_DIV       (BAUD_DIV)
  ) u_uart (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (push),
    .push_dat   (cpu.cpu_dout),
    .fifo_empty (fifo_empty),
    .near_full  (near_full),
    .overflow   (fifo_overflow),
    .uart_tx    (uart_tx)
  );

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: frame-level reference model compared every cycle, plus hand-computed spot values.
module tb_io_bridge;

  localparam int B     = 4;
  localparam int FRAME = 10 * B;
  localparam int DEPTH = 16;
  localparam int SLACK = 2;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk = ~clk;

  io_bridge_if bus();
  logic        ram_en, ram_wr, uart_tx, sim_halt, fifo_overflow;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout, ram_din;

  io_bridge #(.FIFO_DEPTH_LOG(4), .FULL_SLACK(SLACK), .BAUD_DIV(B)) dut (
    .clk_in(clk), .rst_in(rst_in), .cpu(bus),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
    .uart_tx(uart_tx), .sim_halt(sim_halt), .fifo_overflow(fifo_overflow)
  );

  // Block RAM with one-cycle registered read.
  logic [7:0] ram [0:131071];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) ram[ram_a] <= ram_dout;
      else        ram_din <= ram[ram_a];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus position inside the frame currently on the wire.
  logic [7:0] q[$];
  logic       m_busy, m_ovf, m_halt, m_known;
  int         m_t;
  logic [7:0] m_cur, m_din;
  logic [7:0] shadow [0:131071];

  always @(posedge clk or negedge rst_in) begin : model_blk
    logic [17:0] a;
    logic io_acc, pop_now, push_now, accept;
    if (!rst_in) begin
      q.delete();
      m_busy = 1'b0; m_t = 0; m_ovf = 1'b0; m_halt = 1'b0;
      m_known = 1'b1; m_din = 8'h00; m_cur = 8'h00;
    end else begin
      a        = bus.cpu_a[17:0];
      io_acc   = (a[17:16] == 2'b11);
      pop_now  = (q.size() != 0) && (!m_busy || m_t == FRAME - 1);
      push_now = bus.rdy_in && bus.cpu_wr && (a == 18'h30000);
      accept   = push_now && (q.size() < DEPTH || pop_now);
      m_halt   = bus.rdy_in && bus.cpu_wr && (a == 18'h30004);
      if (bus.rdy_in) begin
        m_known = !bus.cpu_wr;
        if (io_acc) m_din = (a == 18'h30004) ? {7'b0, q.size() == 0} : 8'h00;
        else begin
          m_din = shadow[a[16:0]];
          if (bus.cpu_wr) shadow[a[16:0]] = bus.cpu_dout;
        end
      end
      if (m_busy && m_t != FRAME - 1) m_t++;
      else if (pop_now) begin m_cur = q.pop_front(); m_busy = 1'b1; m_t = 0; end
      else m_busy = 1'b0;
      if (accept) q.push_back(bus.cpu_dout);
      else if (push_now) m_ovf = 1'b1;
    end
  end

  function automatic logic exp_tx();
    int pos;
    if (!m_busy) return 1'b1;
    pos = m_t / B;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_cur[pos-1];
  endfunction

  always @(negedge clk) begin : compare_blk
    logic [17:0] a;
    a = bus.cpu_a[17:0];
    check("uart_tx", uart_tx, exp_tx());
    check("io_buffer_full", bus.io_buffer_full, (DEPTH - q.size()) <= SLACK);
    check("fifo_overflow", fifo_overflow, m_ovf);
    check("sim_halt", sim_halt, m_halt);
    if (m_known) check("cpu_din", bus.cpu_din, m_din);
    check("ram_en", ram_en, bus.rdy_in && (a[17:16] != 2'b11));
    check("ram_a", ram_a, a[16:0]);
    check("ram_wr", ram_wr, bus.cpu_wr);
    check("ram_dout", ram_dout, bus.cpu_dout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.rdy_in = 1'b1; bus.cpu_wr = wr; bus.cpu_a = a; bus.cpu_dout = d;
  endtask

  task automatic idle();
    bus.rdy_in = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_a = 32'h0; bus.cpu_dout = 8'h00;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((m_busy || q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    check("drain_timeout", (m_busy || q.size() != 0), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] frame55;
    int ones_seen;
    idle();
    repeat (3) tick();
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_cpu_din", bus.cpu_din, 8'h00);
    check("rst_full", bus.io_buffer_full, 1'b0);
    check("rst_halt", sim_halt, 1'b0);
    check("rst_ovf", fifo_overflow, 1'b0);
    rst_in = 1'b1;
    tick();

    // RAM store then load through an alias with junk upper address bits.
    acc(1'b1, 32'h0000_0100, 8'hA5);
    #1;
    check("ram_store_en", ram_en, 1'b1);
    check("ram_store_wr", ram_wr, 1'b1);
    check("ram_store_a", ram_a, 17'h00100);
    check("ram_store_d", ram_dout, 8'hA5);
    tick();
    acc(1'b0, 32'hFFFC_0100, 8'h00);
    tick();
    check("ram_load_lat1", bus.cpu_din, 8'hA5);
    idle();
    tick();
    check("din_hold_1", bus.cpu_din, 8'hA5);
    tick();
    check("din_hold_2", bus.cpu_din, 8'hA5);
    acc(1'b0, 32'h0003_0000, 8'h00);
    tick();
    check("io_uart_read", bus.cpu_din, 8'h00);

    // Halt pulse, stalled halt write, status read with empty FIFO.
    acc(1'b1, 32'h0003_0004, 8'h00);
    tick();
    check("halt_pulse", sim_halt, 1'b1);
    acc(1'b0, 32'h0003_0004, 8'h00);
    tick();
    check("halt_one_cycle", sim_halt, 1'b0);
    check("status_empty", bus.cpu_din, 8'h01);
    bus.rdy_in = 1'b0; bus.cpu_wr = 1'b1;
    tick();
    check("halt_ignored_stalled", sim_halt, 1'b0);
    idle();
    tick();

    // 0x55: start, LSB-first data 1,0,1,0,1,0,1,0, stop; B cycles per bit.
    frame55 = 10'b1010101010;
    acc(1'b1, 32'h0003_0000, 8'h55);
    tick();
    idle();
    check("tx_idle_at_push", uart_tx, 1'b1);
    for (int k = 0; k < 40; k++) begin
      tick();
      check("tx_0x55", uart_tx, frame55[k/4]);
    end
    tick();
    check("tx_0x55_end", uart_tx, 1'b1);

    // 15 pushes: first byte leaves at once, so the 15th brings the count to 14.
    for (int i = 0; i < 15; i++) begin
      acc(1'b1, 32'h0003_0000, 8'(8'h10 + i));
      tick();
      if (i == 13) check("nf_count13", bus.io_buffer_full, 1'b0);
      if (i == 14) check("nf_count14", bus.io_buffer_full, 1'b1);
    end
    acc(1'b0, 32'h0003_0004, 8'h00);
    tick();
    check("status_nonempty", bus.cpu_din, 8'h00);
    idle();
    for (int e = 17; e <= 42; e++) begin
      tick();
      if (e == 41) check("nf_hold", bus.io_buffer_full, 1'b1);
      if (e == 42) check("nf_fall", bus.io_buffer_full, 1'b0);
    end
    wait_drain(1000);

    // 18 pushes: one goes straight to the shifter, 16 fill the FIFO, the last is dropped.
    for (int i = 0; i < 18; i++) begin
      acc(1'b1, 32'h0003_0000, 8'(8'hA0 + 3 * i));
      tick();
      if (i == 16) check("ovf_before", fifo_overflow, 1'b0);
      if (i == 17) check("ovf_after", fifo_overflow, 1'b1);
    end
    idle();
    check("full_at_16", bus.io_buffer_full, 1'b1);
    wait_drain(1000);
    check("ovf_sticky", fifo_overflow, 1'b1);

    // Reset during data bit 3 of 0xC3 with a second byte still queued.
    acc(1'b1, 32'h0003_0000, 8'hC3);
    tick();
    acc(1'b1, 32'h0003_0000, 8'h3C);
    tick();
    idle();
    repeat (17) tick();
    check("tx_bit3_low", uart_tx, 1'b0);
    rst_in = 1'b0;
    #1;
    check("rst_mid_tx_high", uart_tx, 1'b1);
    check("rst_mid_ovf_clr", fifo_overflow, 1'b0);
    repeat (2) tick();
    rst_in = 1'b1;
    ones_seen = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (uart_tx === 1'b1) ones_seen++;
    end
    check("no_frame_after_rst", ones_seen, 60);
    acc(1'b0, 32'h0003_0004, 8'h00);
    tick();
    check("status_empty_after_rst", bus.cpu_din, 8'h01);
    idle();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
